// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares the single data-RAM port between the CPU memory-access stage, the
//   DMA engine and the debug monitor. One grant per cycle, combinational from
//   the requests and registered state. Debug has top priority and holds a
//   burst lock while it keeps requesting. DMA is promoted above the CPU once it
//   has been refused STARVE_LIMIT cycles in a row. Read data returns one cycle
//   after the grant, tagged to the requester that issued the read.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/we/adr/wdata, cpu_gnt   CPU access (byte enables, 0 = read)
//   cpu_stall_req                   CPU request refused this cycle
//   dma_req/we/adr/wdata, dma_gnt   DMA access (full-word write)
//   dbg_req/we/adr/wdata, dbg_gnt   debug access (full-word write)
//   ram_adr/wdata/wen, ram_rdata    RAM port (read data one cycle later)
//   rdata, *_rvalid                 read data and its owner tag
module dram_port_arbiter #(
  parameter int DWIDTH       = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [DWIDTH-1:0] cpu_adr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall_req,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DWIDTH-1:0] dma_adr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [DWIDTH-1:0] dbg_adr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic [DWIDTH-1:0] ram_adr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wen,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rdata,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic              dbg_rvalid
);

  typedef enum logic {IDLE, DBG_LOCK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [DWIDTH-1:0] adr_q, adr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        rv_q, rv_d;      // {dbg, dma, cpu}
  logic              dma_pri;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Grant and RAM mux
  always_comb begin
    dma_pri       = dma_req && (starve_q == LIMIT);
    dbg_gnt       = dbg_req;
    cpu_gnt       = cpu_req && !dbg_req && !dma_pri;
    dma_gnt       = dma_req && !dbg_req && (dma_pri || !cpu_req);
    cpu_stall_req = cpu_req && !cpu_gnt;

    // idle port keeps address/data still to avoid needless toggling
    ram_adr   = adr_q;
    ram_wdata = wdata_q;
    ram_wen   = 4'b0000;
    if (dbg_gnt) begin
      ram_adr   = dbg_adr;
      ram_wdata = dbg_wdata;
      ram_wen   = {4{dbg_we}};
    end else if (dma_gnt) begin
      ram_adr   = dma_adr;
      ram_wdata = dma_wdata;
      ram_wen   = {4{dma_we}};
    end else if (cpu_gnt) begin
      ram_adr   = cpu_adr;
      ram_wdata = cpu_wdata;
      ram_wen   = cpu_we;
    end
    adr_d   = ram_adr;
    wdata_d = ram_wdata;

    rv_d = {dbg_gnt && !dbg_we, dma_gnt && !dma_we, cpu_gnt && (cpu_we == 4'b0000)};
  end

  // Debug lock FSM and DMA aging
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (dbg_gnt) state_d = DBG_LOCK;
      DBG_LOCK: if (!dbg_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // debug activity freezes the age so a debug burst never promotes DMA
    starve_d = starve_q;
    if (dma_gnt)
      starve_d = 4'd0;
    else if (state_q == DBG_LOCK || dbg_gnt)
      starve_d = starve_q;
    else if (dma_req)
      starve_d = (starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
    else
      starve_d = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      adr_q    <= '0;
      wdata_q  <= 32'd0;
      rv_q     <= 3'b000;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rv_q     <= rv_d;
    end
  end

  assign rdata      = ram_rdata;
  assign cpu_rvalid = rv_q[0];
  assign dma_rvalid = rv_q[1];
  assign dbg_rvalid = rv_q[2];

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;
  localparam int DW    = 11;
  localparam int LIMIT = 4;

  logic clk = 0, rst_n = 0;
  logic cpu_req = 0, dma_req = 0, dbg_req = 0, dma_we = 0, dbg_we = 0;
  logic [3:0] cpu_we = 0;
  logic [DW-1:0] cpu_adr = 0, dma_adr = 0, dbg_adr = 0;
  logic [31:0] cpu_wdata = 0, dma_wdata = 0, dbg_wdata = 0;
  logic cpu_gnt, cpu_stall_req, dma_gnt, dbg_gnt, cpu_rvalid, dma_rvalid, dbg_rvalid;
  logic [DW-1:0] ram_adr;
  logic [31:0] ram_wdata, rdata, ram_rdata;
  logic [3:0] ram_wen;

  int n_chk = 0, n_fail = 0;

  dram_port_arbiter #(.DWIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall_req(cpu_stall_req),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt),
    .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
    .rdata(rdata), .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid), .dbg_rvalid(dbg_rvalid)
  );

  always #5 clk = ~clk;

  // RAM attached to the port: synchronous read of the old word, byte writes
  logic [31:0] ram_mem [2**DW];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_adr];
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) ram_mem[ram_adr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // winner: 0 none, 1 cpu, 2 dma, 3 dbg
  logic [31:0] m_mem [2**DW];
  int          m_starve;
  bit          m_burst;
  bit [2:0]    m_rv;        // {dbg,dma,cpu} expected next cycle
  logic [31:0] m_rd;
  logic [DW-1:0] m_adr;
  logic [31:0] m_wd;

  always @(negedge clk) begin
    int w;
    logic [3:0] e_wen;
    if (!rst_n) begin
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dma_rvalid", dma_rvalid, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      m_starve = 0; m_burst = 0; m_rv = 0; m_adr = 0; m_wd = 0;
    end else begin
      chk("cpu_rvalid", cpu_rvalid, m_rv[0]);
      chk("dma_rvalid", dma_rvalid, m_rv[1]);
      chk("dbg_rvalid", dbg_rvalid, m_rv[2]);
      if (m_rv != 0) chk("rdata", rdata, m_rd);

      if (dbg_req)                              w = 3;
      else if (dma_req && m_starve == LIMIT)    w = 2;
      else if (cpu_req)                         w = 1;
      else if (dma_req)                         w = 2;
      else                                      w = 0;

      e_wen = 4'b0;
      case (w)
        1: begin m_adr = cpu_adr; m_wd = cpu_wdata; e_wen = cpu_we; end
        2: begin m_adr = dma_adr; m_wd = dma_wdata; e_wen = {4{dma_we}}; end
        3: begin m_adr = dbg_adr; m_wd = dbg_wdata; e_wen = {4{dbg_we}}; end
        default: ;
      endcase

      chk("cpu_gnt", cpu_gnt, w == 1);
      chk("dma_gnt", dma_gnt, w == 2);
      chk("dbg_gnt", dbg_gnt, w == 3);
      chk("cpu_stall_req", cpu_stall_req, cpu_req && w != 1);
      chk("ram_wen", ram_wen, e_wen);
      chk("ram_adr", ram_adr, m_adr);
      chk("ram_wdata", ram_wdata, m_wd);

      m_rv = 0;
      if (w != 0 && e_wen == 0) m_rv[w-1] = 1;
      m_rd = m_mem[m_adr];
      for (int b = 0; b < 4; b++)
        if (e_wen[b]) m_mem[m_adr][b*8 +: 8] = m_wd[b*8 +: 8];

      if (w == 2)                 m_starve = 0;
      else if (m_burst || w == 3) m_starve = m_starve;
      else if (dma_req)           m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                        m_starve = 0;
      m_burst = (w == 3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    cpu_req = 0; dma_req = 0; dbg_req = 0;
    cpu_we = 0; dma_we = 0; dbg_we = 0;
  endtask

  initial begin
    int stalls;
    for (int i = 0; i < 2**DW; i++) begin
      ram_mem[i] = 32'hC0DE0000 | i;
      m_mem[i]   = 32'hC0DE0000 | i;
    end
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // idle after reset
    @(negedge clk);
    chk("idle_gnt", {cpu_gnt, dma_gnt, dbg_gnt, cpu_stall_req}, 0);
    chk("idle_wen", ram_wen, 0);
    chk("idle_adr", ram_adr, 0);

    // CPU read of 0x010
    step(); cpu_req = 1; cpu_adr = 11'h010;
    @(negedge clk); chk("cpu_rd_gnt", cpu_gnt, 1);
    step(); idle_all();
    @(negedge clk);
    chk("cpu_rd_rvalid", cpu_rvalid, 1);
    chk("cpu_rd_rdata", rdata, 32'hC0DE0010);

    // CPU vs DMA for 6 cycles: DMA promoted on the fifth
    for (int i = 0; i < 6; i++) begin
      step(); cpu_req = 1; cpu_adr = 11'(i); dma_req = 1; dma_adr = 11'(8'h40 + i);
      @(negedge clk);
      chk("starve_cpu_gnt", cpu_gnt, i != 4);
      chk("starve_dma_gnt", dma_gnt, i == 4);
      chk("starve_stall", cpu_stall_req, i == 4);
    end
    step(); idle_all();

    // debug write burst with CPU waiting
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      step(); dbg_req = 1; dbg_we = 1; dbg_adr = 11'(8'h20 + i); dbg_wdata = 32'hA5A5A5A5;
      cpu_req = 1; cpu_adr = 11'h005;
      @(negedge clk); stalls += int'(cpu_stall_req);
    end
    step(); dbg_req = 0; dbg_we = 0;
    @(negedge clk); stalls += int'(cpu_stall_req);
    chk("burst_cpu_after", cpu_gnt, 1);
    step(); idle_all();
    chk("burst_stalls", stalls, 3);
    step();
    for (int i = 0; i < 3; i++) chk("burst_ram_word", ram_mem[8'h20 + i], 32'hA5A5A5A5);

    // debug read then DMA read back-to-back
    step(); dbg_req = 1; dbg_adr = 11'h021;
    @(negedge clk); chk("alt_dbg_gnt", dbg_gnt, 1);
    step(); dbg_req = 0; dma_req = 1; dma_we = 0; dma_adr = 11'h030;
    @(negedge clk);
    chk("alt_dma_gnt", dma_gnt, 1);
    chk("alt_dbg_rvalid", {dbg_rvalid, dma_rvalid}, 2'b10);
    chk("alt_dbg_rdata", rdata, 32'hA5A5A5A5);
    step(); idle_all();
    @(negedge clk);
    chk("alt_dma_rvalid", {dbg_rvalid, dma_rvalid}, 2'b01);
    chk("alt_dma_rdata", rdata, 32'hC0DE0030);

    // reset during a debug read burst
    step(); dbg_req = 1; dbg_adr = 11'h007;
    step(); dbg_adr = 11'h008;
    #1 rst_n = 0; idle_all();
    #1 chk("rst_mid_rvalid", {cpu_rvalid, dma_rvalid, dbg_rvalid}, 0);
    step(); rst_n = 1; cpu_req = 1; cpu_adr = 11'h009;
    @(negedge clk); chk("rst_mid_cpu_gnt", cpu_gnt, 1);
    step(); idle_all();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        idle_all(); rst_n = 0;
        step(); rst_n = 1;
      end
      cpu_req   = ($urandom_range(0, 9) < 6);
      cpu_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
      cpu_adr   = 11'($urandom_range(0, 63));
      cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 1) != 0);
      dma_we    = ($urandom_range(0, 2) == 0);
      dma_adr   = 11'($urandom_range(0, 63));
      dma_wdata = $urandom;
      dbg_req   = dbg_req ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      dbg_we    = ($urandom_range(0, 1) != 0);
      dbg_adr   = 11'($urandom_range(0, 63));
      dbg_wdata = $urandom;
    end
    step(); idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
